// File: rtl/mux6_rr_arbiter.sv
// mux6_rr_arbiter: round-robin arbiter that drives the select and one-hot grant of a shared 6-input mux.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   req     : per-requester request; bit i pairs with mux input i
//   grant   : registered one-hot grant; zero when the mux is idle
//   sel     : registered mux select (index of the granted requester); zero when idle
//   busy    : high while a grant is active
//   timeout : one-cycle pulse when a grant is force-released
//   Define MUX6_ARB_TIMEOUT_EN to bound each grant to HOLD_MAX cycles.
module mux6_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] req,
  output logic [5:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("HOLD_MAX must be at least 1");
  end
  state_t     state, state_d;
  logic [5:0] grant_d;
  logic [2:0] sel_d, ptr, ptr_d, k;
  logic       busy_d, to_d;
`ifdef MUX6_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  logic [CNT_W-1:0] cnt, cnt_d;
`endif
  // First requesting index at or after ptr, wrapping 5->0; scanning from the
  // far end lets the closest hit overwrite the others.
  always_comb begin
    k = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      j = (j >= 6) ? j - 6 : j;
      if (req[j]) k = 3'(j);
    end
  end
  always_comb begin
    state_d = state;
    grant_d = grant;
    sel_d   = sel;
    busy_d  = busy;
    ptr_d   = ptr;
    to_d    = 1'b0;
`ifdef MUX6_ARB_TIMEOUT_EN
    cnt_d   = cnt;
`endif
    if (state == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        grant_d = 6'b1 << k;
        sel_d   = k;
        busy_d  = 1'b1;
        ptr_d   = (k == 3'd5) ? 3'd0 : k + 3'd1;
`ifdef MUX6_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
    end else if (!req[sel]) begin
      state_d = IDLE;
      grant_d = '0;
      sel_d   = '0;
      busy_d  = 1'b0;
    end
`ifdef MUX6_ARB_TIMEOUT_EN
    else if (cnt == CNT_W'(HOLD_MAX - 1)) begin
      state_d = IDLE;
      grant_d = '0;
      sel_d   = '0;
      busy_d  = 1'b0;
      to_d    = 1'b1;
    end else begin
      cnt_d = cnt + 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      grant   <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      ptr     <= '0;
      timeout <= 1'b0;
`ifdef MUX6_ARB_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_d;
      grant   <= grant_d;
      sel     <= sel_d;
      busy    <= busy_d;
      ptr     <= ptr_d;
      timeout <= to_d;
`ifdef MUX6_ARB_TIMEOUT_EN
      cnt     <= cnt_d;
`endif
    end
  end
endmodule
